// File: rtl/daq_event_builder.sv
// daq_event_builder: packs tlast-delimited 32-bit AXI-Stream packets into 64-bit DAQ events
// framed by a header carrying the event number and a trailer carrying the event word count.
module daq_event_builder #(
  parameter logic [11:0] SOURCE_ID = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic        daq_valid,
  output logic        daq_header,
  output logic        daq_trailer,
  output logic [63:0] daq_data,
  input  logic        daq_ready,
  input  logic        daq_almost_full,
  output logic [23:0] event_count,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, HEADER, WORD0, WORD1, TRAILER} state_t;
  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [23:0] evn_q, evn_d, wc_q, wc_d, ecnt_q, ecnt_d, wc_inc;
  logic        valid_q, valid_d, hdr_q, hdr_d, trl_q, trl_d, acc;
  logic [63:0] data_q, data_d;
  assign s_axis_tready = (state_q == WORD0 || state_q == WORD1) && !daq_almost_full;
  assign acc           = s_axis_tvalid && s_axis_tready;
  assign wc_inc        = (&wc_q) ? wc_q : wc_q + 24'd1;
  assign busy          = state_q != IDLE;
  assign daq_valid     = valid_q;
  assign daq_header    = hdr_q;
  assign daq_trailer   = trl_q;
  assign daq_data      = data_q;
  assign event_count   = ecnt_q;
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    evn_d   = evn_q;
    wc_d    = wc_q;
    ecnt_d  = ecnt_q;
    valid_d = 1'b0;
    hdr_d   = 1'b0;
    trl_d   = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        wc_d = '0;
        if (enable && s_axis_tvalid && daq_ready && !daq_almost_full) state_d = HEADER;
      end
      HEADER: if (!daq_almost_full) begin
        valid_d = 1'b1;
        hdr_d   = 1'b1;
        data_d  = {4'h5, 4'h0, evn_q, 12'h0, SOURCE_ID, 8'h0};
        wc_d    = wc_inc;
        state_d = WORD0;
      end
      WORD0: if (acc) begin
        hi_d = s_axis_tdata;
        if (s_axis_tlast) begin
          valid_d = 1'b1;
          data_d  = {s_axis_tdata, 32'h0};
          wc_d    = wc_inc;
          state_d = TRAILER;
        end else begin
          state_d = WORD1;
        end
      end
      WORD1: if (acc) begin
        valid_d = 1'b1;
        data_d  = {hi_q, s_axis_tdata};
        wc_d    = wc_inc;
        state_d = s_axis_tlast ? TRAILER : WORD0;
      end
      TRAILER: if (!daq_almost_full) begin
        valid_d = 1'b1;
        trl_d   = 1'b1;
        data_d  = {4'hA, 4'h0, wc_inc, 32'h0};
        ecnt_d  = ecnt_q + 24'd1;
        evn_d   = (&evn_q) ? 24'd1 : evn_q + 24'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      evn_q   <= 24'd1;
      wc_q    <= '0;
      ecnt_q  <= '0;
      valid_q <= 1'b0;
      hdr_q   <= 1'b0;
      trl_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      evn_q   <= evn_d;
      wc_q    <= wc_d;
      ecnt_q  <= ecnt_d;
      valid_q <= valid_d;
      hdr_q   <= hdr_d;
      trl_q   <= trl_d;
      data_q  <= data_d;
    end
  end
endmodule
